spi_host_master: RTL
====================

SPI_HOST_MASTER -- requirements
Module: spi_host_master

Interface
REQ-001 Parameter CLK_DIV, default 4, SPI half-period in clk cycles (legal range 2..255).
REQ-002 Parameter DUMMY_BYTES, default 1, turnaround bytes between address and read data (legal range 0..4).
REQ-003 Port clk, input, 1, sole clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port cmd_valid, input, 1, host request valid.
REQ-006 Port cmd_ready, output, 1, request accepted when cmd_valid && cmd_ready.
REQ-007 Port cmd_wr, input, 1, 1 = register write, 0 = register read.
REQ-008 Port cmd_addr, input, 32, register byte address.
REQ-009 Port cmd_wdata, input, 32, write data (ignored for reads).
REQ-010 Port rsp_valid, output, 1, one-cycle pulse marking frame completion.
REQ-011 Port rsp_rdata, output, 32, read data; held until the next rsp_valid.
REQ-012 Port spi_sck, output, 1, SPI clock, mode 0 (idle low).
REQ-013 Port spi_ss_n, output, 1, active-low slave select.
REQ-014 Port spi_mosi, output, 1, master-out data.
REQ-015 Port spi_miso, input, 1, slave-out data.
REQ-016 Port busy, output, 1, high from acceptance until rsp_valid inclusive.

Function
REQ-017 The block SHALL be the SPI master end of the register link: it SHALL originate frames that the device-side SPI slave bridge decodes into register accesses.
REQ-018 Frame, MSB first: opcode byte (0x01 write, 0x02 read), 32-bit address, then for writes 32-bit wdata; for reads DUMMY_BYTES*8 don't-care bits (MOSI=0) followed by 32 read bits.
REQ-019 NBITS = 72 for writes and 40+8*DUMMY_BYTES+32 for reads (80 with default parameters).
REQ-020 FSM states: IDLE, SETUP, SHIFT, HOLD, GAP; IDLE->SETUP on handshake; SETUP->SHIFT after CLK_DIV cycles; SHIFT->HOLD after NBITS sck periods; HOLD->GAP after CLK_DIV cycles; GAP->IDLE after CLK_DIV cycles.
REQ-021 cmd_ready SHALL be 1 only in IDLE; cmd_addr, cmd_wdata and cmd_wr SHALL be captured on the handshake cycle.
REQ-022 spi_ss_n SHALL be driven low from SETUP entry through HOLD exit, and high in IDLE and GAP.
REQ-023 MOSI SHALL present bit 0 of the frame on SETUP entry and change only on sck falling edges; sck SHALL toggle every CLK_DIV cycles in SHIFT, producing NBITS rising edges, and end low.
REQ-024 MISO SHALL be sampled on each sck rising edge; only the final 32 sampled bits of a read SHALL load rsp_rdata, MSB first.
REQ-025 rsp_valid SHALL pulse for one cycle on the GAP->IDLE transition; writes SHALL leave rsp_rdata unchanged.
REQ-026 Frame length SHALL be exactly CLK_DIV*(2*NBITS+3) cycles from handshake to rsp_valid, inclusive of the GAP state.
REQ-027 cmd_valid asserted while busy SHALL be ignored and not queued, and the request SHALL remain pending until cmd_ready.
REQ-028 A reserved-opcode condition cannot arise; cmd_wr alone SHALL select the opcode.

Reset
REQ-029 Asserting rst SHALL immediately force IDLE, spi_sck=0, spi_ss_n=1, spi_mosi=0, cmd_ready=0 while rst=1, rsp_valid=0, busy=0, rsp_rdata=0.
REQ-030 rst mid-frame SHALL abort the frame with no rsp_valid; cmd_ready SHALL rise on the first clk edge after rst deasserts.

Configuration
REQ-031 Macro SPI_MISO_RESYNC_EN: when defined, spi_miso SHALL pass through a 2-flop synchronizer and each MISO sample SHALL be taken 2 clk cycles after the sck rising edge; CLK_DIV SHALL be at least 3.
REQ-032 Without SPI_MISO_RESYNC_EN, MISO SHALL be sampled directly on the cycle sck rises; there is no latency change in either case.

Verification
REQ-033 Write: addr 0x00000010, wdata 0x0000_1F40 -> MOSI bits 0x01,0x00000010,0x00001F40, 72 sck rises, rsp_valid at cycle 4*147=588.
REQ-034 Read: slave model returns 0xDEADBEEF after 1 dummy byte -> rsp_rdata=0xDEADBEEF, 80 sck rises, rsp_valid at cycle 4*163=652.
REQ-035 Back-to-back: cmd_valid held high for two reads -> second handshake occurs exactly one cycle after the first rsp_valid, and ss_n is high for at least CLK_DIV cycles between frames.
REQ-036 Reset mid-SHIFT at bit 30 -> ss_n=1 and sck=0 immediately, no rsp_valid, cmd_ready=1 one cycle after release.
REQ-037 CLK_DIV=2, DUMMY_BYTES=0, and SPI_MISO_RESYNC_EN both defined and undefined (CLK_DIV=3 when defined) -> read of 0x12345678 correct, with frame length per REQ-026.

Source files
------------

// File: rtl/spi_host_master.sv
// SPI mode-0 master that turns host register requests into opcode/address/data frames.
// Optional SPI_MISO_RESYNC_EN: 2-flop MISO synchronizer, samples taken 2 clk after each sck rise.
module spi_host_master #(
    parameter int CLK_DIV     = 4,
    parameter int DUMMY_BYTES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        spi_sck,
    output logic        spi_ss_n,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        busy
);

    localparam int WR_BITS = 72;
    localparam int RD_BITS = 40 + 8 * DUMMY_BYTES + 32;
    localparam int FRAME_W = RD_BITS;

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] PRE_LAST  = 8'(CLK_DIV - 2);
    localparam logic [7:0] WR_LAST   = 8'(WR_BITS - 1);
    localparam logic [7:0] RD_LAST   = 8'(RD_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [7:0]           bit_q, bit_d;
    logic                 sck_q, sck_d;
    logic                 ss_n_q, ss_n_d;
    logic                 wr_q, wr_d;
    logic                 rdy_q, rdy_d;
    logic [FRAME_W-1:0]   tx_q, tx_d;
    logic [31:0]          rx_q, rx_d;
    logic [31:0]          rdata_q, rdata_d;

    logic                 handshake;
    logic                 half_done;
    logic                 rise;
    logic                 sample_en;
    logic                 sample_bit;
    logic [7:0]           bit_last;
    logic [FRAME_W-1:0]   wr_frame;
    logic [FRAME_W-1:0]   rd_frame;

`ifdef SPI_MISO_RESYNC_EN
    logic [1:0]           sync_q, sync_d;
    logic [1:0]           samp_q, samp_d;
`endif

    // Frames are left-aligned so the MSB of tx_q is always the bit on the wire.
    assign wr_frame  = FRAME_W'({8'h01, cmd_addr, cmd_wdata}) << (FRAME_W - WR_BITS);
    assign rd_frame  = FRAME_W'({8'h02, cmd_addr}) << (FRAME_W - 40);

    assign cmd_ready = (state_q == IDLE) && rdy_q;
    assign handshake = cmd_valid && cmd_ready;
    assign half_done = (cnt_q == HALF_LAST);
    assign bit_last  = wr_q ? WR_LAST : RD_LAST;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sck_d   = sck_q;
        wr_d    = wr_q;
        tx_d    = tx_q;
        rdata_d = rdata_q;
        rdy_d   = 1'b1;
        rise    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (handshake) begin
                    state_d = SETUP;
                    wr_d    = cmd_wr;
                    tx_d    = cmd_wr ? wr_frame : rd_frame;
                end
            end
            SETUP: begin
                cnt_d = cnt_q + 8'd1;
                if (half_done) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sck_d   = 1'b1;
                    rise    = 1'b1;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + 8'd1;
                if (half_done) begin
                    cnt_d = '0;
                    if (sck_q) begin
                        sck_d = 1'b0;
                        tx_d  = tx_q << 1;
                    end else if (bit_q == bit_last) begin
                        state_d = HOLD;
                    end else begin
                        bit_d = bit_q + 8'd1;
                        sck_d = 1'b1;
                        rise  = 1'b1;
                    end
                end
            end
            HOLD: begin
                cnt_d = cnt_q + 8'd1;
                if (half_done) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                cnt_d = cnt_q + 8'd1;
                // Read data lands together with the rsp_valid cycle.
                if (cnt_q == PRE_LAST && !wr_q) begin
                    rdata_d = rx_q;
                end
                if (half_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    tx_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        ss_n_d = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));

`ifdef SPI_MISO_RESYNC_EN
        sync_d     = {sync_q[0], spi_miso};
        samp_d     = {samp_q[0], rise};
        sample_en  = samp_q[1];
        sample_bit = sync_q[1];
`else
        sample_en  = rise;
        sample_bit = spi_miso;
`endif
        rx_d = sample_en ? {rx_q[30:0], sample_bit} : rx_q;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            ss_n_q  <= 1'b1;
            wr_q    <= 1'b0;
            rdy_q   <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            ss_n_q  <= ss_n_d;
            wr_q    <= wr_d;
            rdy_q   <= rdy_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef SPI_MISO_RESYNC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            samp_q <= '0;
        end else begin
            sync_q <= sync_d;
            samp_q <= samp_d;
        end
    end
`endif

    assign rsp_valid = (state_q == GAP) && half_done;
    assign rsp_rdata = rdata_q;
    assign busy      = (state_q != IDLE);
    assign spi_sck   = sck_q;
    assign spi_ss_n  = ss_n_q;
    assign spi_mosi  = tx_q[FRAME_W-1];

endmodule
